// File: rtl/serial_add_ctrl.sv
// Serial adder controller: adds two WIDTH-bit operands two bits per clock,
// LSB first, through one shared external 2-bit full-adder slice.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic             slice_cin,
  input  logic [1:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             c_out_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] a_sh_s;
  logic [WIDTH-1:0] b_sh_s;
  logic             last_step_s;

  assign last_step_s = (idx_r == IDX_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; abort outranks the final-digit transition
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else if (last_step_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status flags registered alongside the state they decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
    end
  end

  // Operand capture, digit write-back and inter-slice carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      c_out_r <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= c_in;
            sum_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        RUN: begin
          if (abort) begin
            sum_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
          end else begin
            for (int i = 0; i < N; i++) begin
              if (idx_r == IDX_W'(i)) begin
                sum_r[2*i +: 2] <= slice_sum;
              end
            end
            carry_r <= slice_cout;
            if (last_step_s) begin
              c_out_r <= slice_cout;
              idx_r   <= {IDX_W{1'b0}};
            end else begin
              idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign a_sh_s = a_r >> {idx_r, 1'b0};
  assign b_sh_s = b_r >> {idx_r, 1'b0};

  // Slice operand mux; parked at zero outside RUN
  always_comb begin
    slice_a   = 2'b00;
    slice_b   = 2'b00;
    slice_cin = 1'b0;
    if (state_r == RUN) begin
      slice_a   = a_sh_s[1:0];
      slice_b   = b_sh_s[1:0];
      slice_cin = carry_r;
    end else begin
      slice_a   = 2'b00;
      slice_b   = 2'b00;
      slice_cin = 1'b0;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign c_out = c_out_r;

endmodule
